// File: rtl/fwrisc_lsu.sv
// Load/store stage: computes the effective address, traps illegal or misaligned
// ops, runs one request at a time to fwrisc_mem and reports completion to writeback.
module fwrisc_lsu #(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_base,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_sdata,
    input  logic [4:0]  ex_rd,
    output logic        req_valid,
    output logic [31:0] req_addr,
    output logic [3:0]  req_op,
    output logic [31:0] req_data,
    input  logic        ack_valid,
    input  logic [31:0] ack_data,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_tval
);
    // Shared mem-op encoding: bit 3 marks a store, bits 1:0 give log2(size).
    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LH  = 4'h1;
    localparam logic [3:0] OP_LW  = 4'h2;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;

    typedef enum logic { IDLE, REQ } state_t;

    state_t      state_q, state_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [3:0]  req_op_q, req_op_d;
    logic [31:0] req_data_q, req_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_valid_q, exc_valid_d;
    logic [1:0]  exc_cause_q, exc_cause_d;
    logic [31:0] exc_tval_q, exc_tval_d;

    logic [31:0] eff_addr;
    logic        op_legal, op_store, op_half, op_word, misal;

    always_comb begin
        eff_addr = ex_base + ex_imm;
        op_legal = 1'b1;
        op_store = 1'b0;
        op_half  = 1'b0;
        op_word  = 1'b0;
        case (ex_op)
            OP_LB, OP_LBU: ;
            OP_LH, OP_LHU: op_half = 1'b1;
            OP_LW:         op_word = 1'b1;
            OP_SB:         op_store = 1'b1;
            OP_SH:         begin op_store = 1'b1; op_half = 1'b1; end
            OP_SW:         begin op_store = 1'b1; op_word = 1'b1; end
            default:       op_legal = 1'b0;
        endcase
        misal = MISALIGN_EN && ((op_half && eff_addr[0]) || (op_word && (eff_addr[1:0] != 2'b00)));

        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_op_d    = req_op_q;
        req_data_d  = req_data_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_tval_d  = exc_tval_q;

        case (state_q)
            IDLE: if (ex_valid) begin
                if (!op_legal || misal) begin
                    exc_valid_d = 1'b1;
                    exc_cause_d = !op_legal ? 2'd2 : (op_store ? 2'd1 : 2'd0);
                    exc_tval_d  = eff_addr;
                end else begin
                    req_valid_d = 1'b1;
                    req_addr_d  = eff_addr;
                    req_op_d    = ex_op;
                    req_data_d  = op_store ? ex_sdata : 32'd0;
                    rd_d        = ex_rd;
                    state_d     = REQ;
                end
            end
            REQ: if (ack_valid) begin
                req_valid_d = 1'b0;
                wb_valid_d  = 1'b1;
                wb_data_d   = ack_data;
                wb_rd_d     = rd_q;
                // Only legal ops reach REQ, so bit 3 alone identifies a store.
                wb_we_d     = !req_op_q[3] && (rd_q != 5'd0);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= 32'd0;
            req_op_q    <= 4'd0;
            req_data_q  <= 32'd0;
            rd_q        <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 2'd0;
            exc_tval_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_op_q    <= req_op_d;
            req_data_q  <= req_data_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_tval_q  <= exc_tval_d;
        end
    end

    assign ex_ready  = (state_q == IDLE);
    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign req_op    = req_op_q;
    assign req_data  = req_data_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_tval  = exc_tval_q;
endmodule

// File: tb/tb_fwrisc_lsu.sv
// Scoreboard bench for fwrisc_lsu: stimulus pushes expected outcomes, a monitor
// pops them as requests, writebacks and exceptions appear; a memory model acks.
module tb_fwrisc_lsu;
    localparam logic [3:0] OP_LB = 4'h0, OP_LH = 4'h1, OP_LW = 4'h2, OP_LBU = 4'h4,
                           OP_LHU = 4'h5, OP_SB = 4'h8, OP_SH = 4'h9, OP_SW = 4'hA;

    typedef struct {
        bit          is_exc;
        logic [1:0]  cause;
        logic [31:0] addr;
        logic [3:0]  op;
        logic [31:0] data;
        logic [4:0]  rd;
        bit          we;
    } exp_t;

    logic        clock = 1'b0, reset_n = 1'b0;
    logic        ex_valid = 1'b0, ex_ready;
    logic [3:0]  ex_op = '0;
    logic [31:0] ex_base = '0, ex_imm = '0, ex_sdata = '0;
    logic [4:0]  ex_rd = '0;
    logic        req_valid, ack_valid = 1'b0;
    logic [31:0] req_addr, req_data, ack_data = '0;
    logic [3:0]  req_op;
    logic        wb_valid, wb_we, exc_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_tval;
    logic [1:0]  exc_cause;

    logic        n_ex_valid = 1'b0, n_ex_ready, n_ack_valid = 1'b0;
    logic [3:0]  n_ex_op = '0;
    logic [31:0] n_ex_base = '0, n_ex_imm = '0, n_ex_sdata = '0;
    logic        n_req_valid, n_wb_valid, n_wb_we, n_exc_valid;
    logic [31:0] n_req_addr, n_req_data, n_wb_data, n_exc_tval;
    logic [3:0]  n_req_op;
    logic [4:0]  n_wb_rd;
    logic [1:0]  n_exc_cause;

    int   errors = 0, checks = 0;
    exp_t exp_q[$];
    bit   mon_en = 1'b0, mem_en = 1'b0;
    logic [31:0] last_ack = '0;
    logic ack_in_req_q = 1'b0;
    logic [3:0] legal_ops[8]   = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    logic [3:0] illegal_ops[8] = '{4'h3, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    always #5 clock = ~clock;

    fwrisc_lsu dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_base(ex_base), .ex_imm(ex_imm), .ex_sdata(ex_sdata), .ex_rd(ex_rd),
        .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op), .req_data(req_data),
        .ack_valid(ack_valid), .ack_data(ack_data), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_tval(exc_tval));

    fwrisc_lsu #(.MISALIGN_EN(1'b0)) dut_nm (
        .clock(clock), .reset_n(reset_n), .ex_valid(n_ex_valid), .ex_ready(n_ex_ready),
        .ex_op(n_ex_op), .ex_base(n_ex_base), .ex_imm(n_ex_imm), .ex_sdata(n_ex_sdata), .ex_rd(5'd3),
        .req_valid(n_req_valid), .req_addr(n_req_addr), .req_op(n_req_op), .req_data(n_req_data),
        .ack_valid(n_ack_valid), .ack_data(32'h5A5A5A5A), .wb_valid(n_wb_valid), .wb_we(n_wb_we),
        .wb_rd(n_wb_rd), .wb_data(n_wb_data), .exc_valid(n_exc_valid), .exc_cause(n_exc_cause),
        .exc_tval(n_exc_tval));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference outcome of one op: size-based alignment on the summed address.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] base, input logic [31:0] imm,
                                   input logic [31:0] sdata, input logic [4:0] rd, input bit men);
        exp_t e;
        int   size;
        bit   legal, store;
        e = '{default: '0};
        e.addr = base + imm;
        e.op = op;
        e.rd = rd;
        legal = 1; store = 0; size = 1;
        case (op)
            OP_LB, OP_LBU: size = 1;
            OP_LH, OP_LHU: size = 2;
            OP_LW:         size = 4;
            OP_SB:         begin size = 1; store = 1; end
            OP_SH:         begin size = 2; store = 1; end
            OP_SW:         begin size = 4; store = 1; end
            default:       legal = 0;
        endcase
        e.data = store ? sdata : 32'd0;
        e.we = !store && (rd != 0);
        if (!legal) begin
            e.is_exc = 1; e.cause = 2'd2;
        end else if (men && (e.addr % size) != 0) begin
            e.is_exc = 1; e.cause = store ? 2'd1 : 2'd0;
        end
        return e;
    endfunction

    // Present one op with ex_valid held; called at a negedge, returns at the negedge after acceptance.
    task automatic send(input logic [3:0] op, input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] sdata, input logic [4:0] rd);
        int guard = 0;
        ex_valid = 1'b1; ex_op = op; ex_base = base; ex_imm = imm; ex_sdata = sdata; ex_rd = rd;
        while (!ex_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: ex_ready stayed %b for %0d cycles, expected 1", ex_ready, guard);
        end
        exp_q.push_back(model(op, base, imm, sdata, rd, 1'b1));
        @(negedge clock);
    endtask

    // Memory model: acks each request after 0-5 wait cycles, plus stray acks while idle.
    initial begin
        int wait_cnt = -1;
        int n_acks = 0;
        forever begin
            @(negedge clock);
            ack_valid = 1'b0;
            if (mem_en) begin
                if (req_valid) begin
                    if (wait_cnt < 0) wait_cnt = $urandom_range(0, 5);
                    if (wait_cnt == 0) begin
                        ack_data = (n_acks == 0) ? 32'hDEADBEEF : $urandom;
                        last_ack = ack_data;
                        ack_valid = 1'b1;
                        n_acks++;
                        wait_cnt = -1;
                    end else wait_cnt--;
                end else if ($urandom_range(0, 7) == 0) begin
                    ack_data = $urandom;
                    ack_valid = 1'b1;
                end
            end else wait_cnt = -1;
        end
    end

    always @(posedge clock) ack_in_req_q <= ack_valid && req_valid;

    initial begin
        logic        prev_req = 1'b0;
        logic [31:0] h_addr = '0, h_data = '0;
        logic [3:0]  h_op = '0;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (wb_valid && exc_valid) chk("wb_exc_overlap", {wb_valid, exc_valid}, 2'b10);
                if (ack_in_req_q) chk("req_low_after_ack", req_valid, 1'b0);
                if (exc_valid) begin
                    if (exp_q.size() == 0) chk("unexpected_exc", exc_valid, 1'b0);
                    else begin
                        e = exp_q.pop_front();
                        chk("exc_expected", 1'b1, e.is_exc);
                        chk("exc_cause", exc_cause, e.cause);
                        chk("exc_tval", exc_tval, e.addr);
                    end
                end
                if (req_valid && !prev_req) begin
                    if (exp_q.size() == 0) chk("unexpected_req", req_valid, 1'b0);
                    else begin
                        e = exp_q[0];
                        chk("req_for_exc_op", 1'b0, e.is_exc);
                        chk("req_addr", req_addr, e.addr);
                        chk("req_op", req_op, e.op);
                        chk("req_data", req_data, e.data);
                    end
                    h_addr = req_addr; h_op = req_op; h_data = req_data;
                end else if (req_valid) begin
                    chk("req_addr_stable", req_addr, h_addr);
                    chk("req_op_stable", req_op, h_op);
                    chk("req_data_stable", req_data, h_data);
                end
                if (wb_valid) begin
                    if (exp_q.size() == 0) chk("unexpected_wb", wb_valid, 1'b0);
                    else begin
                        e = exp_q.pop_front();
                        chk("wb_for_exc_op", 1'b0, e.is_exc);
                        chk("wb_we", wb_we, e.we);
                        chk("wb_rd", wb_rd, e.rd);
                        chk("wb_data", wb_data, last_ack);
                    end
                end
            end
            prev_req = req_valid;
        end
    end

    initial begin
        int guard;
        logic [3:0]  op;
        logic [31:0] base, imm;
        repeat (2) @(negedge clock);
        chk("rst_ex_ready", ex_ready, 1'b1);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_req_addr", req_addr, 32'd0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_exc_valid", exc_valid, 1'b0);
        chk("rst_exc_tval", exc_tval, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        mon_en = 1'b1; mem_en = 1'b1;

        send(OP_LW, 32'h1000, 32'h10, 32'h0, 5'd5);
        send(OP_SB, 32'hFFFF_FFFF, 32'h2, 32'h1234_5678, 5'd9);
        send(OP_SW, 32'h2000, 32'h2, 32'hAAAA_5555, 5'd1);
        send(OP_LH, 32'h3000, 32'h0, 32'h0, 5'd0);
        send(4'hF, 32'h4000, 32'h4, 32'h0, 5'd2);
        send(OP_LHU, 32'h5000, 32'hFFFF_FFFF, 32'h0, 5'd4);
        for (int i = 0; i < 120; i++) begin
            if (i % 3 == 0) op = (i % 2) ? OP_SW : OP_LW;
            else if (i % 3 == 1) op = OP_LBU;
            else op = ($urandom_range(0, 7) == 0) ? illegal_ops[$urandom_range(0, 7)]
                                                   : legal_ops[$urandom_range(0, 7)];
            base = $urandom;
            if ($urandom_range(0, 1) == 1) base[1:0] = 2'b00;
            imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 8)) : -32'($urandom_range(0, 8));
            send(op, base, imm, $urandom, 5'($urandom_range(0, 31)));
        end
        ex_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);

        // Asynchronous reset while a request is outstanding.
        mon_en = 1'b0; mem_en = 1'b0;
        repeat (2) @(negedge clock);
        ex_valid = 1'b1; ex_op = OP_LW; ex_base = 32'h3000; ex_imm = 32'h4; ex_rd = 5'd7;
        @(negedge clock);
        ex_valid = 1'b0;
        chk("mid_req_valid", req_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req_valid", req_valid, 1'b0);
        chk("arst_req_addr", req_addr, 32'd0);
        chk("arst_req_op", req_op, 4'd0);
        chk("arst_wb_rd", wb_rd, 5'd0);
        chk("arst_ex_ready", ex_ready, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Misaligned store with the check disabled goes out as a request.
        n_ex_valid = 1'b1; n_ex_op = OP_SW; n_ex_base = 32'h2000; n_ex_imm = 32'h2; n_ex_sdata = 32'hCAFE_F00D;
        @(negedge clock);
        n_ex_valid = 1'b0;
        chk("nm_req_valid", n_req_valid, 1'b1);
        chk("nm_req_addr", n_req_addr, 32'h2002);
        chk("nm_req_data", n_req_data, 32'hCAFE_F00D);
        chk("nm_no_exc", n_exc_valid, 1'b0);
        n_ack_valid = 1'b1;
        @(negedge clock);
        n_ack_valid = 1'b0;
        chk("nm_wb_valid", n_wb_valid, 1'b1);
        chk("nm_wb_we", n_wb_we, 1'b0);
        chk("nm_req_dropped", n_req_valid, 1'b0);
        chk("nm_no_exc_after", n_exc_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
